// File: rtl/data_mem_arbiter_if.sv
// Data-memory arbiter bus: CPU port, DMA/loader port and the single
// data-memory port. The arbiter sits on the slave side. The environment
// (requesters plus memory) sits on the master side.
interface data_mem_arbiter_if;
   // CPU port
   logic       cpu_req;
   logic       cpu_we;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_gnt;
   logic       cpu_stall;
   logic       cpu_rvalid;
   logic [7:0] cpu_rdata;
   // DMA / loader port
   logic       dma_req;
   logic       dma_we;
   logic [7:0] dma_addr;
   logic [7:0] dma_wdata;
   logic       dma_gnt;
   logic       dma_rvalid;
   logic [7:0] dma_rdata;
   // Data memory
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port data-memory arbiter. The CPU normally has priority. The DMA
// port is forced through once it has been denied STARVE_MAX consecutive
// cycles. Grants are combinational, so the access happens in the grant
// cycle. Read data is registered and returned with a one-cycle rvalid pulse.
module data_mem_arbiter #(
   parameter int unsigned STARVE_MAX = 3   // legal range 1..7
) (
   input logic               clk,
   input logic               rst,
   data_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CPU_ACC   = 2'd1,
      DMA_ACC   = 2'd2,
      FORCE_DMA = 2'd3
   } state_t;

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   state_t     state_q, state_d;
   logic [2:0] starve_cnt, starve_d;
   logic       cpu_gnt, dma_gnt;
   logic       cpu_rvalid_q, dma_rvalid_q;
   logic [7:0] cpu_rdata_q, dma_rdata_q;

   // Grant selection, starvation count update and next-state decode
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // one unassigned, which would infer a latch.
      cpu_gnt  = 1'b0;
      dma_gnt  = 1'b0;
      starve_d = 3'd0;
      state_d  = IDLE;

      if (!rst) begin
         if (bus.dma_req && (!bus.cpu_req || state_q == FORCE_DMA)) begin
            dma_gnt = 1'b1;
         end else if (bus.cpu_req) begin
            cpu_gnt = 1'b1;
         end
      end

      // A denied DMA request ages; a grant or a dropped request clears it.
      if (bus.dma_req && !dma_gnt) begin
         starve_d = (starve_cnt == 3'd7) ? 3'd7 : starve_cnt + 3'd1;
      end

      if (dma_gnt) begin
         state_d = DMA_ACC;
      end else if (cpu_gnt) begin
         state_d = CPU_ACC;
      end
      if (starve_d == STARVE_LIM) begin
         state_d = FORCE_DMA;
      end
   end

   // State and starvation counter registers
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples values from before the edge.
      if (rst) begin
         state_q    <= IDLE;
         starve_cnt <= 3'd0;
      end else begin
         state_q    <= state_d;
         starve_cnt <= starve_d;
      end
   end

   // Memory port mux driven by the granted requester
   always_comb begin
      bus.mem_addr  = 8'h00;
      bus.mem_wdata = 8'h00;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      if (cpu_gnt) begin
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
         bus.mem_read  = ~bus.cpu_we;
         bus.mem_write = bus.cpu_we;
      end else if (dma_gnt) begin
         bus.mem_addr  = bus.dma_addr;
         bus.mem_wdata = bus.dma_wdata;
         bus.mem_read  = ~bus.dma_we;
         bus.mem_write = bus.dma_we;
      end
   end

   // Capture read data at the end of a read grant and flag it for one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
         cpu_rdata_q  <= 8'h00;
         dma_rdata_q  <= 8'h00;
      end else begin
         cpu_rvalid_q <= cpu_gnt & ~bus.cpu_we;
         dma_rvalid_q <= dma_gnt & ~bus.dma_we;
         if (cpu_gnt && !bus.cpu_we) begin
            cpu_rdata_q <= bus.mem_rdata;
         end
         if (dma_gnt && !bus.dma_we) begin
            dma_rdata_q <= bus.mem_rdata;
         end
      end
   end

   // Port outputs. Read-return registers are masked while rst is high so a
   // read granted just before reset never shows up as a valid response.
   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.dma_gnt    = dma_gnt;
   assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
   assign bus.cpu_rvalid = cpu_rvalid_q & ~rst;
   assign bus.dma_rvalid = dma_rvalid_q & ~rst;
   assign bus.cpu_rdata  = rst ? 8'h00 : cpu_rdata_q;
   assign bus.dma_rdata  = rst ? 8'h00 : dma_rdata_q;

endmodule
